// File: rtl/fb_id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, backpressure hold,
// flush-to-bubble and a saturating count of inserted load-use bubbles.
module fb_id_ex_reg #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_is_load,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              ex_valid_q,    ex_valid_d;
  logic [31:0]       ex_pc_q,       ex_pc_d;
  logic [31:0]       ex_imm_q,      ex_imm_d;
  logic [31:0]       ex_rs1_data_q, ex_rs1_data_d;
  logic [31:0]       ex_rs2_data_q, ex_rs2_data_d;
  logic [4:0]        ex_rs1_q,      ex_rs1_d;
  logic [4:0]        ex_rs2_q,      ex_rs2_d;
  logic [4:0]        ex_rd_q,       ex_rd_d;
  logic              ex_is_load_q,  ex_is_load_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;

  logic hazard;
  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd_q);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd_q);
  assign hazard    = id_valid && ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
                     (rs1_match || rs2_match);

  assign id_stall  = !reset && !flush && (!ex_ready || hazard);

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_is_load_d  = ex_is_load_q;
    ex_ctrl_d     = ex_ctrl_q;
    bubble_cnt_d  = bubble_cnt_q;

    if (flush || (ex_ready && (hazard || !id_valid))) begin
      // Bubbles zero every field so an idle EX stage sees deterministic values.
      ex_valid_d    = 1'b0;
      ex_pc_d       = '0;
      ex_imm_d      = '0;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
      ex_rs1_d      = '0;
      ex_rs2_d      = '0;
      ex_rd_d       = '0;
      ex_is_load_d  = 1'b0;
      ex_ctrl_d     = '0;
      if (!flush && hazard && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else if (ex_ready) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = id_pc;
      ex_imm_d      = id_imm;
      ex_rs1_data_d = id_rs1_data;
      ex_rs2_data_d = id_rs2_data;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_is_load_d  = id_is_load;
      ex_ctrl_d     = id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_is_load_q  <= 1'b0;
      ex_ctrl_q     <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_ctrl_q     <= ex_ctrl_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_is_load  = ex_is_load_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule
